// File: rtl/cvita_pkt_parser.sv
// cvita_pkt_parser: CHDR receive-side parser on a 64-bit AXI-Stream.
// Strips the header word (and timestamp word when has_time=1), forwards the
// payload with zero latency, and presents {header, timestamp} on o_hdr.
// Header layout used: [63:62] pkt_type, [61] has_time, [47:32] length (bytes).
// Optional statistics counters are enabled by defining CVITA_PKT_PARSER_STATS_EN.
module cvita_pkt_parser #(
   parameter logic [3:0] PASS_TYPES = 4'b1111,
   parameter int         CNT_W      = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [63:0]  i_tdata,
   input  logic         i_tlast,
   input  logic         i_tvalid,
   output logic         i_tready,
   output logic [63:0]  o_tdata,
   output logic         o_tlast,
   output logic         o_tvalid,
   input  logic         o_tready,
   output logic [127:0] o_hdr,
   output logic         o_hdr_only,
   output logic         err_len,
   output logic         err_trunc,
   input  logic         stat_clear,
   output logic [31:0]  stat_pkts,
   output logic [31:0]  stat_words,
   output logic [63:0]  stat_xor
);

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_TIME = 2'd1,
      ST_BODY = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [127:0]       hdr_q, hdr_d;
   logic               hdr_only_q, hdr_only_d;
   logic               err_len_q, err_len_d;
   logic               err_trunc_q, err_trunc_d;
   logic               rdy_s, vld_s, last_s;
   logic               pkt_done_s, body_xfer_s;
   logic [CNT_W-1:0]   cnt_inc_s;
   logic [1:0]         in_type_s;
   logic               in_time_s;

   // Saturating increment: a counter that has reached all-ones stays there.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         sat_inc = v;
      end else begin
         sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   // Length is good when it equals 8*beats or 8*beats-4; a saturated count is never good.
   function automatic logic len_bad(input logic [15:0] len, input logic [CNT_W-1:0] cnt);
      logic [CNT_W+18:0] len_x;
      logic [CNT_W+18:0] bytes_x;
      len_x   = {{(CNT_W+3){1'b0}}, len};
      bytes_x = {16'd0, cnt, 3'b000};
      len_bad = (&cnt) | ((len_x != bytes_x) &
                          (len_x != (bytes_x - {{(CNT_W+16){1'b0}}, 3'd4})));
   endfunction

   assign cnt_inc_s = sat_inc(cnt_q);
   assign in_type_s = i_tdata[63:62];
   assign in_time_s = i_tdata[61];

   // Next-state, counter, header latch and handshake decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hdr_d       = hdr_q;
      hdr_only_d  = 1'b0;
      err_len_d   = 1'b0;
      err_trunc_d = 1'b0;
      rdy_s       = 1'b0;
      vld_s       = 1'b0;
      last_s      = 1'b0;
      pkt_done_s  = 1'b0;
      body_xfer_s = 1'b0;
      case (state_q)
         ST_HDR: begin
            rdy_s = 1'b1;
            if (i_tvalid) begin
               hdr_d = {i_tdata, 64'd0};
               cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
               if (!PASS_TYPES[in_type_s]) begin
                  state_d = i_tlast ? ST_HDR : ST_DROP;
               end else if (in_time_s) begin
                  if (i_tlast) begin
                     err_trunc_d = 1'b1;
                     state_d     = ST_HDR;
                  end else begin
                     state_d = ST_TIME;
                  end
               end else if (i_tlast) begin
                  hdr_only_d = 1'b1;
                  err_len_d  = len_bad(i_tdata[47:32], {{(CNT_W-1){1'b0}}, 1'b1});
                  pkt_done_s = 1'b1;
                  state_d    = ST_HDR;
               end else begin
                  state_d = ST_BODY;
               end
            end else begin
               state_d = ST_HDR;
            end
         end
         ST_TIME: begin
            rdy_s = 1'b1;
            if (i_tvalid) begin
               hdr_d[63:0] = i_tdata;
               cnt_d       = cnt_inc_s;
               if (i_tlast) begin
                  hdr_only_d = 1'b1;
                  err_len_d  = len_bad(hdr_q[111:96], cnt_inc_s);
                  pkt_done_s = 1'b1;
                  state_d    = ST_HDR;
               end else begin
                  state_d = ST_BODY;
               end
            end else begin
               state_d = ST_TIME;
            end
         end
         ST_BODY: begin
            rdy_s  = o_tready;
            vld_s  = i_tvalid;
            last_s = i_tlast;
            if (i_tvalid && o_tready) begin
               cnt_d       = cnt_inc_s;
               body_xfer_s = 1'b1;
               if (i_tlast) begin
                  err_len_d  = len_bad(hdr_q[111:96], cnt_inc_s);
                  pkt_done_s = 1'b1;
                  state_d    = ST_HDR;
               end else begin
                  state_d = ST_BODY;
               end
            end else begin
               state_d = ST_BODY;
            end
         end
         ST_DROP: begin
            rdy_s = 1'b1;
            if (i_tvalid && i_tlast) begin
               state_d = ST_HDR;
            end else begin
               state_d = ST_DROP;
            end
         end
         default: begin
            state_d = ST_HDR;
         end
      endcase
   end

   // State, counter, header and pulse registers; reset abandons any packet in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_HDR;
         cnt_q       <= {CNT_W{1'b0}};
         hdr_q       <= 128'd0;
         hdr_only_q  <= 1'b0;
         err_len_q   <= 1'b0;
         err_trunc_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hdr_q       <= hdr_d;
         hdr_only_q  <= hdr_only_d;
         err_len_q   <= err_len_d;
         err_trunc_q <= err_trunc_d;
      end
   end

   // Handshake is masked during the reset cycle so nothing is accepted or offered.
   assign i_tready   = rdy_s  & ~reset;
   assign o_tvalid   = vld_s  & ~reset;
   assign o_tlast    = last_s & ~reset;
   assign o_tdata    = i_tdata;
   assign o_hdr      = hdr_q;
   assign o_hdr_only = hdr_only_q;
   assign err_len    = err_len_q;
   assign err_trunc  = err_trunc_q;

`ifdef CVITA_PKT_PARSER_STATS_EN
   logic [31:0] stat_pkts_q, stat_words_q;
   logic [63:0] stat_xor_q;

   // Forwarded-traffic statistics; clear takes priority over a same-cycle update.
   always_ff @(posedge clk) begin
      if (reset || stat_clear) begin
         stat_pkts_q  <= 32'd0;
         stat_words_q <= 32'd0;
         stat_xor_q   <= 64'd0;
      end else begin
         if (pkt_done_s) begin
            stat_pkts_q <= stat_pkts_q + 32'd1;
         end else begin
            stat_pkts_q <= stat_pkts_q;
         end
         if (body_xfer_s) begin
            stat_words_q <= stat_words_q + 32'd1;
            stat_xor_q   <= stat_xor_q ^ i_tdata;
         end else begin
            stat_words_q <= stat_words_q;
            stat_xor_q   <= stat_xor_q;
         end
      end
   end

   assign stat_pkts  = stat_pkts_q;
   assign stat_words = stat_words_q;
   assign stat_xor   = stat_xor_q;
`else
   logic unused_stats_s;
   assign unused_stats_s = ^{stat_clear, pkt_done_s, body_xfer_s};
   assign stat_pkts  = 32'd0;
   assign stat_words = 32'd0;
   assign stat_xor   = 64'd0;
`endif

endmodule

// File: tb/tb_cvita_pkt_parser.sv
// Bench for cvita_pkt_parser: two instances (all types passed / DATA only)
// share one input stream; directed cases followed by randomized packets,
// checked against a packet-level reference model.
module tb_cvita_pkt_parser;

   localparam logic [3:0] PASS_A = 4'b1111;
   localparam logic [3:0] PASS_B = 4'b0001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, i_tlast, i_tvalid, o_tready, stat_clear;
   logic [63:0]  i_tdata;
   logic         a_i_tready, a_o_tlast, a_o_tvalid, a_hdr_only, a_err_len, a_err_trunc;
   logic [63:0]  a_o_tdata, a_xor;
   logic [127:0] a_o_hdr;
   logic [31:0]  a_pkts, a_words;
   logic         b_i_tready, b_o_tlast, b_o_tvalid, b_hdr_only, b_err_len, b_err_trunc;
   logic [63:0]  b_o_tdata, b_xor;
   logic [127:0] b_o_hdr;
   logic [31:0]  b_pkts, b_words;

   cvita_pkt_parser #(.PASS_TYPES(PASS_A), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
      .i_tready(a_i_tready), .o_tdata(a_o_tdata), .o_tlast(a_o_tlast), .o_tvalid(a_o_tvalid),
      .o_tready(o_tready), .o_hdr(a_o_hdr), .o_hdr_only(a_hdr_only), .err_len(a_err_len),
      .err_trunc(a_err_trunc), .stat_clear(stat_clear), .stat_pkts(a_pkts),
      .stat_words(a_words), .stat_xor(a_xor));

   cvita_pkt_parser #(.PASS_TYPES(PASS_B), .CNT_W(16)) dut_f (
      .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
      .i_tready(b_i_tready), .o_tdata(b_o_tdata), .o_tlast(b_o_tlast), .o_tvalid(b_o_tvalid),
      .o_tready(o_tready), .o_hdr(b_o_hdr), .o_hdr_only(b_hdr_only), .err_len(b_err_len),
      .err_trunc(b_err_trunc), .stat_clear(stat_clear), .stat_pkts(b_pkts),
      .stat_words(b_words), .stat_xor(b_xor));

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] pay_a [8];
   bit          pa_len, pa_ho, pa_tr, pb_len, pb_ho, pb_tr;
   int unsigned m_pkts, m_words;
   logic [63:0] m_xor;
   bit          tog_bit;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Packet-level rules: which pulses a whole packet should produce.
   function automatic void model_flags(input logic [3:0] mask, input logic [1:0] typ, input bit ht,
                                       input int npay, input int len,
                                       output bit f_len, output bit f_ho, output bit f_tr);
      int nb;
      f_len = 1'b0; f_ho = 1'b0; f_tr = 1'b0;
      if (mask[typ]) begin
         if (ht && npay < 0) begin
            f_tr = 1'b1;
         end else begin
            nb    = 1 + int'(ht) + npay;
            f_ho  = (npay == 0);
            f_len = (len != 8 * nb) && (len != 8 * nb - 4);
         end
      end
   endfunction

   task automatic check_pulses();
      chk("a_err_len", a_err_len, pa_len);
      chk("a_hdr_only", a_hdr_only, pa_ho);
      chk("a_err_trunc", a_err_trunc, pa_tr);
      chk("b_err_len", b_err_len, pb_len);
      chk("b_hdr_only", b_hdr_only, pb_ho);
      chk("b_err_trunc", b_err_trunc, pb_tr);
      pa_len = 0; pa_ho = 0; pa_tr = 0; pb_len = 0; pb_ho = 0; pb_tr = 0;
   endtask

   task automatic chk_stats();
      logic [31:0] e_p, e_w;
      logic [63:0] e_x;
`ifdef CVITA_PKT_PARSER_STATS_EN
      e_p = m_pkts; e_w = m_words; e_x = m_xor;
`else
      e_p = 32'd0; e_w = 32'd0; e_x = 64'd0;
`endif
      chk("stat_pkts", a_pkts, e_p);
      chk("stat_words", a_words, e_w);
      chk("stat_xor", a_xor, e_x);
   endtask

   task automatic idle(input int n);
      i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check_pulses();
         chk("idle_a_o_tvalid", a_o_tvalid, 1'b0);
         chk("idle_b_o_tvalid", b_o_tvalid, 1'b0);
         @(posedge clk); #1;
      end
   endtask

   task automatic mid_reset();
      reset = 1'b1; i_tvalid = 1'b1; i_tdata = 64'hDEAD; i_tlast = 1'b0; o_tready = 1'b1;
      @(negedge clk);
      chk("rst_a_i_tready", a_i_tready, 1'b0);
      chk("rst_a_o_tvalid", a_o_tvalid, 1'b0);
      chk("rst_a_o_tlast", a_o_tlast, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0; i_tvalid = 1'b0;
      pa_len = 0; pa_ho = 0; pa_tr = 0; pb_len = 0; pb_ho = 0; pb_tr = 0;
      m_pkts = 0; m_words = 0; m_xor = 64'd0;
      @(negedge clk);
      chk("rst_a_o_hdr", a_o_hdr, 128'd0);
      check_pulses();
      chk_stats();
      @(posedge clk); #1;
   endtask

   // Drive one packet; npay<0 with ht=1 means a truncated single-beat packet.
   task automatic send_pkt(input logic [1:0] typ, input bit ht, input logic [63:0] ts,
                           input int npay, input logic [15:0] len, input bit tog, input int abort_at);
      logic [63:0] hdr;
      logic [63:0] beats [12];
      logic [11:0] seq;
      logic [31:0] sid;
      int nb;
      bit trunc, body, last, acc, fa_len, fa_ho, fa_tr, fb_len, fb_ho, fb_tr;
      seq   = 12'($urandom);
      sid   = $urandom;
      hdr   = {typ, ht, 1'b0, seq, len, sid};
      trunc = ht && (npay < 0);
      nb    = trunc ? 1 : 1 + int'(ht) + npay;
      beats[0] = hdr;
      if (ht && !trunc) beats[1] = ts;
      for (int p = 0; p < npay; p++) beats[1 + int'(ht) + p] = pay_a[p];
      model_flags(PASS_A, typ, ht, npay, int'(len), fa_len, fa_ho, fa_tr);
      model_flags(PASS_B, typ, ht, npay, int'(len), fb_len, fb_ho, fb_tr);
      for (int b = 0; b < nb; b++) begin
         last = (b == nb - 1);
         body = !trunc && (b >= 1 + int'(ht));
         i_tdata = beats[b]; i_tlast = last; i_tvalid = 1'b1;
         acc = 1'b0;
         while (!acc) begin
            if (tog) begin
               o_tready = tog_bit; tog_bit = !tog_bit;
            end else begin
               o_tready = 1'b1;
            end
            @(negedge clk);
            check_pulses();
            chk("a_o_tvalid", a_o_tvalid, body && PASS_A[typ]);
            chk("b_o_tvalid", b_o_tvalid, body && PASS_B[typ]);
            chk("a_i_tready", a_i_tready, (body && PASS_A[typ]) ? o_tready : 1'b1);
            chk("b_i_tready", b_i_tready, (body && PASS_B[typ]) ? o_tready : 1'b1);
            if (body && PASS_A[typ]) begin
               chk("a_o_tdata", a_o_tdata, beats[b]);
               chk("a_o_tlast", a_o_tlast, last);
               chk("a_o_hdr", a_o_hdr, {hdr, ht ? ts : 64'd0});
            end
            if (body && PASS_B[typ]) begin
               chk("b_o_hdr", b_o_hdr, {hdr, ht ? ts : 64'd0});
            end
            acc = (body && PASS_A[typ]) ? o_tready : 1'b1;
            @(posedge clk); #1;
         end
         if (body && PASS_A[typ]) begin
            m_words++;
            m_xor ^= beats[b];
         end
         if (last) begin
            pa_len = fa_len; pa_ho = fa_ho; pa_tr = fa_tr;
            pb_len = fb_len; pb_ho = fb_ho; pb_tr = fb_tr;
            if (PASS_A[typ] && !trunc) m_pkts++;
         end
         if (b == abort_at) begin
            mid_reset();
            return;
         end
      end
      i_tvalid = 1'b0; i_tlast = 1'b0;
   endtask

   initial begin
      logic [1:0] t;
      bit ht;
      int np, nbk, l;
      reset = 1'b1; i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = 64'd0; o_tready = 1'b1;
      stat_clear = 1'b0; tog_bit = 1'b1;
      pa_len = 0; pa_ho = 0; pa_tr = 0; pb_len = 0; pb_ho = 0; pb_tr = 0;
      m_pkts = 0; m_words = 0; m_xor = 64'd0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset_a_i_tready", a_i_tready, 1'b0);
      chk("reset_b_i_tready", b_i_tready, 1'b0);
      chk("reset_a_o_tvalid", a_o_tvalid, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset_o_hdr", a_o_hdr, 128'd0);
      chk("reset_o_tlast", a_o_tlast, 1'b0);
      check_pulses();
      chk_stats();
      @(posedge clk); #1;

      // DATA, no time, len 40, payload 1..4
      for (int p = 0; p < 4; p++) pay_a[p] = 64'(p + 1);
      send_pkt(2'd0, 1'b0, 64'd0, 4, 16'd40, 1'b0, -1);
      idle(2);
      // DATA with timestamp, len 28 (8*4-4)
      pay_a[0] = 64'hA5A5_0000_0000_0001; pay_a[1] = 64'h5A5A_0000_0000_0002;
      send_pkt(2'd0, 1'b1, 64'h1234, 2, 16'd28, 1'b0, -1);
      idle(2);
      // length mismatch: header says 48, only 4 beats
      send_pkt(2'd0, 1'b0, 64'd0, 3, 16'd48, 1'b0, -1);
      idle(2);
      // FC packet then DATA back-to-back (dropped by the DATA-only instance)
      send_pkt(2'd1, 1'b0, 64'd0, 2, 16'd24, 1'b0, -1);
      send_pkt(2'd0, 1'b0, 64'd0, 2, 16'd24, 1'b0, -1);
      idle(2);
      // truncated timestamp packet, then CMD header-only
      send_pkt(2'd0, 1'b1, 64'd0, -1, 16'd16, 1'b0, -1);
      send_pkt(2'd2, 1'b0, 64'd0, 0, 16'd8, 1'b0, -1);
      idle(2);
      chk_stats();

      // randomized packets
      for (int k = 0; k < 24; k++) begin
         t  = 2'($urandom_range(0, 3));
         ht = 1'($urandom_range(0, 1));
         np = $urandom_range(0, 4);
         if (ht && $urandom_range(0, 4) == 0) np = -1;
         nbk = (np < 0) ? 1 : 1 + int'(ht) + np;
         case ($urandom_range(0, 2))
            0:       l = 8 * nbk;
            1:       l = 8 * nbk - 4;
            default: l = $urandom_range(0, 200);
         endcase
         for (int p = 0; p < 8; p++) pay_a[p] = {$urandom, $urandom};
         send_pkt(t, ht, {$urandom, $urandom}, np, 16'(l), (t == 2'd0) && ($urandom_range(0, 1) == 1), -1);
         if ($urandom_range(0, 2) == 0) idle(1);
      end
      idle(2);
      chk_stats();

      // reset mid-body with toggling ready, then a fresh packet
      for (int p = 0; p < 4; p++) pay_a[p] = {$urandom, $urandom};
      tog_bit = 1'b1;
      send_pkt(2'd0, 1'b0, 64'd0, 4, 16'd40, 1'b1, 2);
      pay_a[0] = 64'hF0; pay_a[1] = 64'h0F;
      tog_bit = 1'b1;
      send_pkt(2'd0, 1'b0, 64'd0, 2, 16'd24, 1'b1, -1);
      idle(2);
      chk_stats();

      // statistics clear
      stat_clear = 1'b1;
      @(posedge clk); #1;
      stat_clear = 1'b0;
      m_pkts = 0; m_words = 0; m_xor = 64'd0;
      @(negedge clk);
      chk_stats();
      @(posedge clk); #1;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
